// File: rtl/codeconv_ctrl.sv
// codeconv_ctrl: handshake controller that sequences an external binary/Gray byte converter
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_data/in_mode       upstream request
//   cv_start/cv_convert/cv_data_in          converter command
//   cv_data_out/cv_done                     converter result
//   out_valid/out_ready/out_data/out_mode/out_err  downstream result
//   txn_count                               completed non-error results (saturating)
module codeconv_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_mode,
  output logic        cv_start,
  output logic        cv_convert,
  output logic [7:0]  cv_data_in,
  input  logic [7:0]  cv_data_out,
  input  logic        cv_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_mode,
  output logic        out_err,
  output logic [15:0] txn_count
);
  localparam logic [2:0] IDLE = 3'd0, ARM = 3'd1, START = 3'd2, WAIT = 3'd3, SETTLE = 3'd4, OUT = 3'd5;
  logic [2:0] state;
  logic [7:0] cnt;
  assign in_ready  = state == IDLE;
  assign cv_start  = state == START;
  assign out_valid = state == OUT;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      cv_data_in <= 8'd0;
      cv_convert <= 1'b0;
      out_data   <= 8'd0;
      out_mode   <= 1'b0;
      out_err    <= 1'b0;
      txn_count  <= 16'd0;
    end else
      case (state)
        IDLE:
          if (in_valid) begin
            cv_data_in <= in_data;
            cv_convert <= in_mode;
            state      <= ARM;
          end
        // a converter still showing a stale done must drop it before a new start
        ARM:    state <= cv_done ? ARM : START;
        START: begin
          cnt   <= 8'd0;
          state <= WAIT;
        end
        // done takes priority over a timeout landing in the same cycle
        WAIT:
          if (cv_done) state <= SETTLE;
          else if (cnt == 8'(TIMEOUT - 1)) begin
            out_data <= 8'd0;
            out_mode <= cv_convert;
            out_err  <= 1'b1;
            state    <= OUT;
          end else cnt <= cnt + 8'd1;
        SETTLE: begin
          out_data <= cv_data_out;
          out_mode <= cv_convert;
          out_err  <= 1'b0;
          state    <= OUT;
        end
        OUT:
          if (out_ready) begin
            state <= IDLE;
            if (!out_err && txn_count != 16'hFFFF) txn_count <= txn_count + 16'd1;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_codeconv_ctrl.sv
// tb_codeconv_ctrl: randomized self-checking bench with a behavioural converter and golden Gray model
module tb_codeconv_ctrl;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_mode = 0, out_ready = 0, done_force = 0;
  logic [7:0] in_data = 0;
  logic in_ready, cv_start, cv_convert, cv_done, out_valid, out_mode, out_err;
  logic [7:0] cv_data_in, out_data;
  logic [15:0] txn_count;
  logic [7:0] cv_data_out = 0, op = 0;
  logic cv_done_r = 0, md = 0;
  int cv_delay = 3, cnt = 0, hold = 0;
  bit cv_hang = 0;
  int cyc = 0, starts = 0, start_cyc = 0;
  int checks = 0, passes = 0;

  codeconv_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .cv_start(cv_start), .cv_convert(cv_convert), .cv_data_in(cv_data_in),
    .cv_data_out(cv_data_out), .cv_done(cv_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode), .out_err(out_err), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] b2g(input logic [7:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [7:0] g2b(input logic [7:0] x);
    logic [7:0] r = 0;
    for (int i = 0; i < 8; i++) r ^= x >> i;
    return r;
  endfunction

  assign cv_done = cv_done_r | done_force;

  always @(posedge clk)
    if (cv_start) begin
      cnt <= cv_hang ? 0 : cv_delay;
      op  <= cv_data_in;
      md  <= cv_convert;
    end else if (cnt == 1) begin
      cnt         <= 0;
      cv_done_r   <= 1'b1;
      cv_data_out <= md ? g2b(op) : b2g(op);
      hold        <= 3;
    end else if (cnt > 1) cnt <= cnt - 1;
    else if (hold == 1) begin
      hold      <= 0;
      cv_done_r <= 1'b0;
    end else if (hold > 1) hold <= hold - 1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cv_start) begin
      starts    <= starts + 1;
      start_cyc <= cyc;
    end
  end

  task automatic send(input logic [7:0] d, input logic m, input int stall,
                      output logic [7:0] od, output logic om, output logic oe, output int lat, output int unstable);
    int n = 0;
    unstable = 0; lat = -1; od = 0; om = 0; oe = 0;
    in_valid = 1; in_data = d; in_mode = m;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 0; in_data = 8'($urandom); in_mode = 1'($urandom);
    while (!out_valid && n < 400) begin @(negedge clk); n++; end
    if (!out_valid) begin
      checks++;
      $display("FAIL send_timeout out_valid=%b required 1 within bound", out_valid);
      return;
    end
    lat = cyc - start_cyc; od = out_data; om = out_mode; oe = out_err;
    repeat (stall) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_data !== od || out_mode !== om || out_err !== oe) unstable++;
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || cv_start !== 1'b0) $display("FAIL reset_ctl got rdy=%b vld=%b st=%b required 1 0 0", in_ready, out_valid, cv_start); else passes++;
    checks++; if (out_data !== 8'h00 || out_err !== 1'b0 || out_mode !== 1'b0) $display("FAIL reset_out got %h %b %b required 00 0 0", out_data, out_err, out_mode); else passes++;
    checks++; if (cv_data_in !== 8'h00 || cv_convert !== 1'b0 || txn_count !== 16'd0) $display("FAIL reset_cv got %h %b %0d required 00 0 0", cv_data_in, cv_convert, txn_count); else passes++;
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] od; logic om, oe; int lat, u, s0;
    s0 = starts; cv_delay = 3;
    send(8'hA3, 1'b0, 0, od, om, oe, lat, u);
    checks++; if (starts - s0 !== 1) $display("FAIL basic_starts got %0d required 1", starts - s0); else passes++;
    checks++; if (od !== 8'hF2 || om !== 1'b0 || oe !== 1'b0) $display("FAIL basic_result got %h %b %b required f2 0 0", od, om, oe); else passes++;
    checks++; if (lat !== 6) $display("FAIL basic_latency got %0d required 6", lat); else passes++;
    checks++; if (txn_count !== 16'd1) $display("FAIL basic_count got %0d required 1", txn_count); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL basic_idle got %b required 1", in_ready); else passes++;
  endtask

  task automatic test_stall();
    logic [7:0] od; logic om, oe; int lat, u;
    cv_delay = 2;
    send(8'h80, 1'b1, 5, od, om, oe, lat, u);
    checks++; if (od !== 8'hFF || om !== 1'b1 || oe !== 1'b0) $display("FAIL stall_result got %h %b %b required ff 1 0", od, om, oe); else passes++;
    checks++; if (u !== 0) $display("FAIL stall_stable got %0d unstable cycles required 0", u); else passes++;
    checks++; if (txn_count !== 16'd2) $display("FAIL stall_count got %0d required 2", txn_count); else passes++;
  endtask

  task automatic test_arm();
    logic [7:0] od; logic om, oe; int lat, u, s0;
    done_force = 1; s0 = starts; cv_delay = 4;
    fork
      send(8'h3C, 1'b0, 0, od, om, oe, lat, u);
      begin
        repeat (5) @(negedge clk);
        checks++; if (starts !== s0) $display("FAIL arm_hold got %0d starts required 0", starts - s0); else passes++;
        done_force = 0;
      end
    join
    checks++; if (starts - s0 !== 1) $display("FAIL arm_starts got %0d required 1", starts - s0); else passes++;
    checks++; if (od !== b2g(8'h3C) || oe !== 1'b0) $display("FAIL arm_result got %h %b required %h 0", od, oe, b2g(8'h3C)); else passes++;
  endtask

  task automatic test_timeout();
    logic [7:0] od; logic om, oe; int lat, u;
    logic [15:0] tc0;
    tc0 = txn_count; cv_hang = 1;
    send(8'h5A, 1'b1, 1, od, om, oe, lat, u);
    cv_hang = 0;
    checks++; if (od !== 8'h00 || oe !== 1'b1 || om !== 1'b1) $display("FAIL timeout_result got %h %b %b required 00 1 1", od, oe, om); else passes++;
    checks++; if (lat !== 17) $display("FAIL timeout_latency got %0d required 17", lat); else passes++;
    checks++; if (txn_count !== tc0) $display("FAIL timeout_count got %0d required %0d", txn_count, tc0); else passes++;
  endtask

  task automatic test_collide();
    logic [7:0] od; logic om, oe; int lat, u;
    cv_delay = 15;
    send(8'hC7, 1'b1, 0, od, om, oe, lat, u);
    checks++; if (od !== g2b(8'hC7) || oe !== 1'b0 || lat !== 18) $display("FAIL collide_done got %h %b lat %0d required %h 0 18", od, oe, lat, g2b(8'hC7)); else passes++;
    cv_delay = 16;
    send(8'hC7, 1'b1, 0, od, om, oe, lat, u);
    checks++; if (od !== 8'h00 || oe !== 1'b1 || lat !== 17) $display("FAIL collide_late got %h %b lat %0d required 00 1 17", od, oe, lat); else passes++;
  endtask

  task automatic test_reset_wait();
    logic [7:0] od; logic om, oe; int lat, u, s0, n;
    cv_hang = 1; s0 = starts; n = 0;
    in_valid = 1; in_data = 8'h3C; in_mode = 1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 0;
    while (starts == s0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1;
    checks++; if (out_valid !== 1'b0 || cv_start !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstwait_ctl got vld=%b st=%b rdy=%b required 0 0 1", out_valid, cv_start, in_ready); else passes++;
    checks++; if (cv_data_in !== 8'h00 || cv_convert !== 1'b0 || txn_count !== 16'd0) $display("FAIL rstwait_regs got %h %b %0d required 00 0 0", cv_data_in, cv_convert, txn_count); else passes++;
    @(negedge clk);
    reset = 0; cv_hang = 0; cv_delay = 2;
    @(negedge clk);
    send(8'h55, 1'b0, 0, od, om, oe, lat, u);
    checks++; if (od !== 8'h7F || om !== 1'b0 || oe !== 1'b0) $display("FAIL rstwait_next got %h %b %b required 7f 0 0", od, om, oe); else passes++;
    checks++; if (txn_count !== 16'd1) $display("FAIL rstwait_count got %0d required 1", txn_count); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] od, d, exp; logic om, oe, m; int lat, u;
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 22; i++) begin
      d = 8'($urandom); m = 1'(i & 1);
      cv_delay = $urandom_range(1, 6);
      send(d, m, $urandom_range(0, 2), od, om, oe, lat, u);
      exp = m ? g2b(d) : b2g(d);
      checks++; if (od !== exp || om !== m || oe !== 1'b0 || u !== 0) $display("FAIL b2b_%0d in %h mode %b got %h %b %b required %h %b 0", i, d, m, od, om, oe, exp, m); else passes++;
    end
    checks++; if (txn_count !== 16'd22) $display("FAIL b2b_count got %0d required 22", txn_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_arm();
    test_timeout();
    test_collide();
    test_reset_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
